// File: rtl/main_fsm.sv
// Multicycle ARM-subset control FSM: Moore state machine with ALU decode, PC-source request and
// an optional retired-fetch counter enabled by defining INSTR_COUNT_EN.
module main_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rd,
  output logic        IRWrite,
  output logic        NextPC,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic [1:0]  FlagW,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        PCS,
  output logic [31:0] InstrCount
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  logic [3:0] state_q, state_d;
  logic       alu_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      // writeback/terminal states and unused encodings all return to FETCH
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    alu_dec    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD:    AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: alu_dec = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_dec = 1'b1;
      end
      S_ALUWB:    RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: ;
    endcase
    if (alu_dec) begin
      case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
      // logic ops (AND/ORR) update only N/Z; add/sub also update C/V
      FlagW = {Funct[0], Funct[0] & ~ALUControl[1]};
    end
  end

  assign PCS    = (RegW & (Rd == 4'hF)) | Branch;
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_cnt_q, instr_cnt_d;

  assign instr_cnt_d = (state_q == S_FETCH) ? instr_cnt_q + 32'd1 : instr_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instr_cnt_q <= 32'd0;
    else       instr_cnt_q <= instr_cnt_d;
  end

  assign InstrCount = instr_cnt_q;
`else
  assign InstrCount = 32'd0;
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Randomized bench for main_fsm: per-instruction phase lists and per-phase output rules form the
// reference; covers directed sequences, mid-instruction reset, unused encodings and the counter.
module tb_main_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic        IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, PCS;
  logic [1:0]  ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc;
  logic [31:0] InstrCount;
  logic [19:0] outs;
  logic [31:0] exp_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .FlagW(FlagW), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .PCS(PCS), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  assign outs = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ALUControl, FlagW, ImmSrc, RegSrc, PCS};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output vector for a named phase; "X" stands for an unused state encoding.
  function automatic logic [19:0] exp_out(input string ph, input logic [1:0] op,
                                          input logic [5:0] fn, input logic [3:0] rd);
    logic irw = 0, npc = 0, regw = 0, memw = 0, br = 0, adr = 0, asa = 0, exe = 0;
    logic [1:0] asb = 0, rs = 0, alu = 0, fw = 0;
    case (ph)
      "F":  begin irw = 1; npc = 1; asa = 1; asb = 2; rs = 2; end
      "D":  begin asa = 1; asb = 2; rs = 2; end
      "MA": asb = 1;
      "MR": adr = 1;
      "MB": begin rs = 1; regw = 1; end
      "MW": begin adr = 1; memw = 1; end
      "ER": exe = 1;
      "EI": begin asb = 1; exe = 1; end
      "AW": regw = 1;
      "BR": begin asb = 1; rs = 2; br = 1; end
      default: ;
    endcase
    if (exe) begin
      if      (fn[4:1] == 4'b0010) alu = 1;
      else if (fn[4:1] == 4'b0000) alu = 2;
      else if (fn[4:1] == 4'b1100) alu = 3;
      else                         alu = 0;
      fw = {fn[0], fn[0] && (alu < 2)};
    end
    return {irw, npc, regw, memw, br, adr, asa, asb, rs, alu, fw, op,
            op == 2'b01, op == 2'b10, (regw && rd == 4'hF) || br};
  endfunction

  // Runs one instruction from FETCH; rst_at >= 0 asserts reset right after that phase.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                           input int rst_at);
    string seq[$];
    case (op)
      2'b00: seq = fn[5] ? '{"F", "D", "EI", "AW"} : '{"F", "D", "ER", "AW"};
      2'b01: seq = fn[0] ? '{"F", "D", "MA", "MR", "MB"} : '{"F", "D", "MA", "MW"};
      2'b10: seq = '{"F", "D", "BR"};
      default: seq = '{"F", "D"};
    endcase
    Op = op; Funct = fn; Rd = rd;
    foreach (seq[i]) begin
      #1;
      chk({"ph_", seq[i]}, {12'd0, outs}, {12'd0, exp_out(seq[i], op, fn, rd)});
      chk({"cnt_", seq[i]}, InstrCount, exp_cnt);
      if (i == rst_at) begin
        reset = 1'b1;
        exp_cnt = 0;
        #1;
        chk("rst_async", {12'd0, outs}, {12'd0, exp_out("F", op, fn, rd)});
        chk("rst_cnt", InstrCount, exp_cnt);
        @(negedge clk);
        #1;
        chk("rst_hold", {12'd0, outs}, {12'd0, exp_out("F", op, fn, rd)});
        reset = 1'b0;
        return;
      end
`ifdef INSTR_COUNT_EN
      if (seq[i] == "F") exp_cnt = exp_cnt + 1;
`endif
      @(negedge clk);
    end
  endtask

  task automatic illegal_state(input logic [3:0] code);
    #1 force dut.state_q = code;
    #1 release dut.state_q;
    #1 chk("unused_enc", {12'd0, outs}, {12'd0, exp_out("X", Op, Funct, Rd)});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; exp_cnt = 0;
    #3;
    chk("reset_out", {12'd0, outs}, {12'd0, exp_out("F", Op, Funct, Rd)});
    chk("reset_cnt", InstrCount, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(2'b00, 6'b101001, 4'b0011, -1);   // ADDS imm
    run_instr(2'b01, 6'b011001, 4'b1111, -1);   // LDR to PC
    run_instr(2'b01, 6'b011000, 4'b0010, -1);   // STR
    run_instr(2'b10, 6'b100000, 4'b0000, -1);   // B
    run_instr(2'b00, 6'b000001, 4'b1111, -1);   // ANDS reg to PC
    run_instr(2'b00, 6'b011000, 4'b1111, -1);   // ORR reg, no flags
    run_instr(2'b11, 6'b111111, 4'b1111, -1);   // undefined
    run_instr(2'b01, 6'b011001, 4'b0100, 3);    // reset during MEMRD
    run_instr(2'b00, 6'b101001, 4'b0001, -1);
    illegal_state(4'd10);
    illegal_state(4'd15);
    run_instr(2'b10, 6'b000000, 4'b0000, -1);

`ifdef INSTR_COUNT_EN
    reset = 1'b1; #1; reset = 1'b0; exp_cnt = 0;
    for (int k = 0; k < 3; k++) run_instr(2'b10, 6'd0, 4'd0, -1);
    #1 chk("cnt_3br", InstrCount, 32'd3);
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.instr_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    run_instr(2'b10, 6'd0, 4'd0, -1);
    #1 chk("cnt_wrap", InstrCount, 32'd0);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] rd;
      int         ra;
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      if ($urandom_range(0, 15) == 0) illegal_state(4'($urandom_range(10, 15)));
      run_instr(op, fn, rd, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
